// File: rtl/uart_rx_frame.sv
// UART receive framer: start-bit detection, 3-sample mid-bit majority vote,
// LSB-first data capture, optional parity check and 1 or 2 stop bits.
// All framing state advances only on oversample ticks (i_en); the publish
// pulse on o_valid is a single i_clk cycle regardless of tick rate.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | line idle, waiting for a tick with i_rx low
// S_START  | inside start bit; false start rejected at the vote tick
// S_DATA   | shifting in DATA_BITS data bits, LSB first
// S_PARITY | voting the parity bit (only when PARITY != 0)
// S_STOP   | voting stop bit(s); frame published at the final vote tick
module uart_rx_frame #(
  parameter int OSR       = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_en,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_busy
);

  localparam int TW = $clog2(OSR);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] T_S0   = TW'(OSR / 2 - 1);
  localparam logic [TW-1:0] T_S1   = TW'(OSR / 2);
  localparam logic [TW-1:0] T_VOTE = TW'(OSR / 2 + 1);
  localparam logic [TW-1:0] T_LAST = TW'(OSR - 1);

  localparam logic [BW-1:0] B_LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] B_LAST_STOP = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e                 state_q, state_d;
  logic [TW-1:0]          tick_q, tick_d;
  logic [BW-1:0]          bitn_q, bitn_d;
  logic                   smp0_q, smp0_d;
  logic                   smp1_q, smp1_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   perr_out_q, perr_out_d;
  logic                   ferr_out_q, ferr_out_d;

  logic                   vote;
  logic                   at_vote;
  logic                   at_last;
  logic [TW-1:0]          tick_inc;

  // Third vote sample is the live line at the vote tick, so no third register.
  assign vote     = (smp0_q & smp1_q) | (smp0_q & i_rx) | (smp1_q & i_rx);
  assign at_vote  = (tick_q == T_VOTE);
  assign at_last  = (tick_q == T_LAST);
  assign tick_inc = at_last ? '0 : tick_q + TW'(1);

  // Next-state, counters, sampling, and publish decision.
  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bitn_d     = bitn_q;
    smp0_d     = smp0_q;
    smp1_d     = smp1_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    perr_out_d = perr_out_q;
    ferr_out_d = ferr_out_q;

    if (i_en) begin
      if (state_q != S_IDLE) begin
        tick_d = tick_inc;
        if (tick_q == T_S0) smp0_d = i_rx;
        if (tick_q == T_S1) smp1_d = i_rx;
      end

      case (state_q)
        S_IDLE: begin
          if (!i_rx) begin
            // This tick is tick 0 of the start bit.
            state_d = S_START;
            tick_d  = TW'(1);
            bitn_d  = '0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
          end
        end

        S_START: begin
          if (at_vote && vote) begin
            state_d = S_IDLE;
            tick_d  = '0;
          end else if (at_last) begin
            state_d = S_DATA;
            bitn_d  = '0;
          end
        end

        S_DATA: begin
          if (at_vote) shift_d = {vote, shift_q[DATA_BITS-1:1]};
          if (at_last) begin
            if (bitn_q == B_LAST_DATA) begin
              state_d = (PARITY != 0) ? S_PARITY : S_STOP;
              bitn_d  = '0;
            end else begin
              bitn_d = bitn_q + BW'(1);
            end
          end
        end

        S_PARITY: begin
          if (at_vote) perr_d = (PARITY == 2) ? ~(^shift_q ^ vote) : (^shift_q ^ vote);
          if (at_last) begin
            state_d = S_STOP;
            bitn_d  = '0;
          end
        end

        S_STOP: begin
          if (at_vote) begin
            ferr_d = ferr_q | ~vote;
            if (bitn_q == B_LAST_STOP) begin
              // Leave at mid-bit so the next start edge has half a bit of slack.
              data_d     = shift_q;
              perr_out_d = perr_q;
              ferr_out_d = ferr_q | ~vote;
              valid_d    = 1'b1;
              state_d    = S_IDLE;
              tick_d     = '0;
            end
          end else if (at_last) begin
            bitn_d = bitn_q + BW'(1);
          end
        end

        default: begin
          state_d = S_IDLE;
          tick_d  = '0;
        end
      endcase
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      tick_q     <= '0;
      bitn_q     <= '0;
      smp0_q     <= 1'b0;
      smp1_q     <= 1'b0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      bitn_q     <= bitn_d;
      smp0_q     <= smp0_d;
      smp1_q     <= smp1_d;
      shift_q    <= shift_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_out_q <= perr_out_d;
      ferr_out_q <= ferr_out_d;
    end
  end

  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_parity_err = perr_out_q;
  assign o_frame_err  = ferr_out_q;
  assign o_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: 8E1 instance (dut_a) plus an 8E2
// instance (dut_b) for the two-stop-bit frame error case.
module tb_uart_rx_frame;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic rx = 1'b1;
  logic sel2 = 1'b0;
  logic rx_a, rx_b;

  assign rx_a = sel2 ? 1'b1 : rx;
  assign rx_b = sel2 ? rx : 1'b1;

  logic [7:0] a_data, b_data;
  logic a_valid, a_pe, a_fe, a_busy;
  logic b_valid, b_pe, b_fe, b_busy;

  uart_rx_frame #(.OSR(16), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_rx(rx_a),
    .o_data(a_data), .o_valid(a_valid), .o_parity_err(a_pe),
    .o_frame_err(a_fe), .o_busy(a_busy)
  );

  uart_rx_frame #(.OSR(16), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_rx(rx_b),
    .o_data(b_data), .o_valid(b_valid), .o_parity_err(b_pe),
    .o_frame_err(b_fe), .o_busy(b_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vec = 0;
  int errs = 0;
  int gap = 1;

  // Capture of published frames, sampled away from the active edge.
  int ma_cnt = 0, ma_cyc = 0, ma_wide = 0;
  logic [7:0] ma_dat = '0, ma_dat_prev = '0;
  logic ma_pe = 1'b0, ma_fe = 1'b0, ma_prev = 1'b0;
  int mb_cnt = 0;
  logic [7:0] mb_dat = '0;
  logic mb_pe = 1'b0, mb_fe = 1'b0;

  always @(negedge clk) begin
    ma_prev <= a_valid;
    if (a_valid) begin
      ma_cnt      <= ma_cnt + 1;
      ma_cyc      <= cyc;
      ma_dat_prev <= ma_dat;
      ma_dat      <= a_data;
      ma_pe       <= a_pe;
      ma_fe       <= a_fe;
      if (ma_prev) ma_wide <= ma_wide + 1;
    end
    if (b_valid) begin
      mb_cnt <= mb_cnt + 1;
      mb_dat <= b_data;
      mb_pe  <= b_pe;
      mb_fe  <= b_fe;
    end
  end

  task automatic do_tick(input logic v, output int c);
    @(negedge clk);
    c  = cyc;
    en = 1'b1;
    rx = v;
    for (int i = 1; i < gap; i++) begin
      @(negedge clk);
      en = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    int c;
    for (int i = 0; i < n; i++) do_tick(1'b1, c);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  // bits: start, d[0..7], parity, stop1, stop2 (stop2 sent only if nstop==2)
  task automatic send_frame(input logic [7:0] d, input logic pbit, input int nstop,
                            input logic stop1, input logic stop2,
                            input int gl_bit, input int gl_tick, output int scyc);
    logic [11:0] bits;
    logic v;
    int c;
    bits     = '0;
    bits[0]  = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
    bits[9]  = pbit;
    bits[10] = stop1;
    bits[11] = stop2;
    scyc = 0;
    for (int b = 0; b < 10 + nstop; b++) begin
      for (int t = 0; t < 16; t++) begin
        v = bits[b];
        if (b == gl_bit && t == gl_tick) v = ~v;
        do_tick(v, c);
        if (b == 0 && t == 0) scyc = c;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vec++; if (a_data !== 8'h00) begin errs++; $display("FAIL reset_data: got %h expected 00", a_data); end
    vec++; if (a_valid !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b expected 0", a_valid); end
    vec++; if ({a_pe, a_fe} !== 2'b00) begin errs++; $display("FAIL reset_errs: got %b expected 00", {a_pe, a_fe}); end
    vec++; if ({a_busy, b_busy} !== 2'b00) begin errs++; $display("FAIL reset_busy: got %b expected 00", {a_busy, b_busy}); end
    rst_n = 1'b1;
    idle(4);
  endtask

  task automatic test_basic();
    int s, c0;
    c0 = ma_cnt;
    send_frame(8'hA5, 1'b0, 1, 1'b1, 1'b1, -1, -1, s);
    idle(4);
    settle();
    vec++; if (ma_cnt !== c0 + 1) begin errs++; $display("FAIL basic_count: got %0d expected %0d", ma_cnt, c0 + 1); end
    vec++; if (ma_dat !== 8'hA5) begin errs++; $display("FAIL basic_data: got %h expected a5", ma_dat); end
    vec++; if ({ma_pe, ma_fe} !== 2'b00) begin errs++; $display("FAIL basic_errs: got %b expected 00", {ma_pe, ma_fe}); end
    vec++; if (ma_cyc - s !== 170) begin errs++; $display("FAIL basic_latency: got %0d expected 170", ma_cyc - s); end
    vec++; if (a_busy !== 1'b0) begin errs++; $display("FAIL basic_busy: got %b expected 0", a_busy); end
  endtask

  task automatic test_parity();
    int s;
    send_frame(8'h3C, 1'b1, 1, 1'b1, 1'b1, -1, -1, s);
    idle(4);
    settle();
    vec++; if (ma_dat !== 8'h3C) begin errs++; $display("FAIL parity_bad_data: got %h expected 3c", ma_dat); end
    vec++; if ({ma_pe, ma_fe} !== 2'b10) begin errs++; $display("FAIL parity_bad_errs: got %b expected 10", {ma_pe, ma_fe}); end
    send_frame(8'h3C, 1'b0, 1, 1'b1, 1'b1, -1, -1, s);
    idle(4);
    settle();
    vec++; if ({ma_pe, ma_fe} !== 2'b00) begin errs++; $display("FAIL parity_clear_errs: got %b expected 00", {ma_pe, ma_fe}); end
  endtask

  task automatic test_frame_err();
    int s, c0;
    send_frame(8'hFF, 1'b0, 1, 1'b0, 1'b1, -1, -1, s);
    idle(20);
    settle();
    vec++; if (ma_dat !== 8'hFF) begin errs++; $display("FAIL ferr_data: got %h expected ff", ma_dat); end
    vec++; if ({ma_pe, ma_fe} !== 2'b01) begin errs++; $display("FAIL ferr_errs: got %b expected 01", {ma_pe, ma_fe}); end
    c0 = ma_cnt;
    sel2 = 1'b1;
    send_frame(8'hFF, 1'b0, 2, 1'b1, 1'b0, -1, -1, s);
    idle(20);
    settle();
    sel2 = 1'b0;
    vec++; if (mb_cnt !== 1) begin errs++; $display("FAIL ferr2_count: got %0d expected 1", mb_cnt); end
    vec++; if (mb_dat !== 8'hFF) begin errs++; $display("FAIL ferr2_data: got %h expected ff", mb_dat); end
    vec++; if ({mb_pe, mb_fe} !== 2'b01) begin errs++; $display("FAIL ferr2_errs: got %b expected 01", {mb_pe, mb_fe}); end
    vec++; if (ma_cnt !== c0) begin errs++; $display("FAIL ferr2_isolation: got %0d expected %0d", ma_cnt, c0); end
  endtask

  task automatic test_false_start();
    int s, c, c0;
    c0 = ma_cnt;
    for (int i = 0; i < 5; i++) do_tick(1'b0, c);
    for (int i = 0; i < 4; i++) do_tick(1'b1, c);
    settle();
    vec++; if (a_busy !== 1'b1) begin errs++; $display("FAIL false_busy_tick8: got %b expected 1", a_busy); end
    do_tick(1'b1, c);
    settle();
    vec++; if (a_busy !== 1'b0) begin errs++; $display("FAIL false_busy_tick9: got %b expected 0", a_busy); end
    idle(20);
    settle();
    vec++; if (ma_cnt !== c0) begin errs++; $display("FAIL false_no_valid: got %0d expected %0d", ma_cnt, c0); end
    send_frame(8'h00, 1'b0, 1, 1'b1, 1'b1, -1, -1, s);
    idle(4);
    settle();
    vec++; if (ma_cnt !== c0 + 1) begin errs++; $display("FAIL false_next_count: got %0d expected %0d", ma_cnt, c0 + 1); end
    vec++; if ({ma_dat, ma_pe, ma_fe} !== 10'h000) begin errs++; $display("FAIL false_next_frame: got %h expected 000", {ma_dat, ma_pe, ma_fe}); end
  endtask

  task automatic test_break();
    int c, c0;
    c0 = ma_cnt;
    for (int i = 0; i < 176; i++) do_tick(1'b0, c);
    idle(20);
    settle();
    vec++; if (ma_cnt !== c0 + 1) begin errs++; $display("FAIL break_count: got %0d expected %0d", ma_cnt, c0 + 1); end
    vec++; if ({ma_dat, ma_pe, ma_fe} !== 10'h001) begin errs++; $display("FAIL break_frame: got %h expected 001", {ma_dat, ma_pe, ma_fe}); end
  endtask

  task automatic test_glitch_slow();
    int s;
    gap = 3;
    send_frame(8'h55, 1'b0, 1, 1'b1, 1'b1, 4, 8, s);
    idle(4);
    gap = 1;
    idle(2);
    settle();
    vec++; if (ma_dat !== 8'h55) begin errs++; $display("FAIL glitch_data: got %h expected 55", ma_dat); end
    vec++; if ({ma_pe, ma_fe} !== 2'b00) begin errs++; $display("FAIL glitch_errs: got %b expected 00", {ma_pe, ma_fe}); end
    vec++; if (ma_cyc - s !== 508) begin errs++; $display("FAIL glitch_latency: got %0d expected 508", ma_cyc - s); end
  endtask

  task automatic test_back_to_back();
    int s, c, c0;
    c0 = ma_cnt;
    do_tick(1'b0, c);
    for (int i = 1; i < 16; i++) do_tick(1'b0, c);
    for (int b = 0; b < 4; b++)
      for (int t = 0; t < 16; t++) do_tick(b[0] ? 1'b0 : 1'b1, c);
    for (int t = 0; t < 8; t++) do_tick(1'b0, c);
    @(negedge clk);
    rst_n = 1'b0;
    rx = 1'b1;
    #1;
    vec++; if (a_data !== 8'h00) begin errs++; $display("FAIL rst_mid_data: got %h expected 00", a_data); end
    vec++; if ({a_valid, a_busy} !== 2'b00) begin errs++; $display("FAIL rst_mid_valid_busy: got %b expected 00", {a_valid, a_busy}); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(5);
    settle();
    vec++; if (ma_cnt !== c0) begin errs++; $display("FAIL rst_mid_no_valid: got %0d expected %0d", ma_cnt, c0); end
    send_frame(8'h12, 1'b0, 1, 1'b1, 1'b1, -1, -1, s);
    send_frame(8'h34, 1'b1, 1, 1'b1, 1'b1, -1, -1, s);
    idle(4);
    settle();
    vec++; if (ma_cnt !== c0 + 2) begin errs++; $display("FAIL b2b_count: got %0d expected %0d", ma_cnt, c0 + 2); end
    vec++; if (ma_dat_prev !== 8'h12) begin errs++; $display("FAIL b2b_first: got %h expected 12", ma_dat_prev); end
    vec++; if (ma_dat !== 8'h34) begin errs++; $display("FAIL b2b_second: got %h expected 34", ma_dat); end
    vec++; if ({ma_pe, ma_fe} !== 2'b00) begin errs++; $display("FAIL b2b_errs: got %b expected 00", {ma_pe, ma_fe}); end
    vec++; if (ma_wide !== 0) begin errs++; $display("FAIL valid_width: got %0d wide pulses expected 0", ma_wide); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_frame_err();
    test_false_start();
    test_break();
    test_glitch_slow();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Parametrised UART receive framer: detects the start bit, majority-vote samples each bit at mid-bit, shifts in 5–9 LSB-first data bits, and checks optional parity and 1 or 2 stop bits. It replaces the fixed 8N1 data-bit capture stage in the UART RX path and is self-contained: it needs no external start strobe. It sits between the RX input synchroniser / oversample tick generator and the byte consumer (FIFO or CPU register).

## Interface
- `OSR`, 16: oversample ticks per bit; must be even and ≥ 4.
- `DATA_BITS`, 8: data bits per frame, 5..9.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: 1 or 2.

Ports (clock and reset first):
- `i_clk`  in  1  system clock.
- `i_rst_n`  in  1  reset. Asynchronous assert, active-low.
- `i_en`  in  1  oversample tick strobe. One cycle high per 1/OSR bit time. All state advances only on `i_en`=1.
- `i_rx`  in  1  serial line, already synchronised to `i_clk`. Idle level is 1.
- `o_data`  out  DATA_BITS  last received word; bit 0 is the first bit received.
- `o_valid`  out  1  one-`i_clk` pulse when a frame completes.
- `o_parity_err`  out  1  parity mismatch on the last frame. Always 0 when `PARITY`=0.
- `o_frame_err`  out  1  at least one stop bit sampled as 0 on the last frame.
- `o_busy`  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Counters:
  - `tick` counts 0..OSR-1 within a bit; width $clog2(OSR).
  - `bitn` counts bits within a phase; width $clog2(DATA_BITS+1).
- Vote: sample `i_rx` on ticks OSR/2-1, OSR/2 and OSR/2+1. The bit value is the majority of the 3 samples, evaluated at tick OSR/2+1.
- IDLE: on `i_en` with `i_rx`=0, go to START. That tick is tick 0.
- START:
  - At tick OSR/2+1, if the vote is 1 (false start), return to IDLE. Nothing is output.
  - Otherwise, at tick OSR-1 go to DATA with `bitn`=0.
- DATA:
  - At each vote, shift the voted bit into the shift register MSB end. After DATA_BITS bits, `o_data` holds the word LSB-first.
  - At tick OSR-1 of the last data bit, go to PARITY if `PARITY`≠0, otherwise to STOP.
- PARITY:
  - Vote the parity bit.
  - Error if the XOR of data and parity bit is 1 (`PARITY`=1, even) or 0 (`PARITY`=2, odd).
  - At tick OSR-1, go to STOP.
- STOP:
  - Vote each stop bit. Any stop bit voted 0 sets the frame error.
  - At the vote tick of the final stop bit, publish the frame and go directly to IDLE. This gives a half-bit of resync margin for back-to-back frames.
- Publish (registered):
  - On the `i_clk` cycle after the final vote tick, load `o_data` and both error flags and pulse `o_valid`.
  - The data word is delivered even when an error flag is set.
- Outputs hold their values until the next publish.
- `o_busy` is combinational from state.

## Timing
- Reset values: `o_data`=0, `o_valid`=0, `o_parity_err`=0, `o_frame_err`=0, `o_busy`=0. State is IDLE; counters and vote samples are 0.
- Frame length in bits: N = 1 + DATA_BITS + (PARITY≠0) + STOP_BITS.
- Latency, measured from the `i_en` cycle that first sees `i_rx`=0:
  - The final vote occurs on tick (N-1)·OSR + OSR/2+1.
  - `o_valid` is high on the `i_clk` cycle after that tick.
  - With `i_en` tied high, OSR=16, 8E1 (N=11), `o_valid` is high 170 cycles later.
- `o_valid` is exactly one `i_clk` cycle wide, independent of the `i_en` rate.
- With `i_en`=0, all state and counters hold. `i_rx` is ignored.
- A new start edge may be accepted on the `i_en` tick after the publish tick. Falling edges seen in STOP after the final vote are handled by IDLE on the next tick.
- Reset mid-frame: all outputs and state clear immediately; no `o_valid` is produced. The next full frame after release is received normally.
- `i_rx` held low continuously (break): the frame completes with `o_data`=0 and `o_frame_err`=1. START is then re-entered on the next tick. No special break handling is provided.

## Test plan
All scenarios use OSR=16, DATA_BITS=8, PARITY=1, STOP_BITS=1, `i_en`=1, unless noted.
1. Send 0xA5 with parity 0 and stop 1 -> `o_valid` pulse 170 cycles after the start edge; `o_data`=0xA5; both errors 0; `o_busy` low after publish.
2. Send 0x3C with parity 1 (wrong) -> `o_data`=0x3C, `o_parity_err`=1. Then send 0x3C with parity 0 -> error clears.
3. Send 0xFF with stop bit 0 -> `o_data`=0xFF, `o_frame_err`=1. Repeat with STOP_BITS=2 and only the second stop bit 0 -> `o_frame_err`=1.
4. Drive `i_rx` low for 5 ticks, then high -> no `o_valid`; `o_busy` falls at tick 9. A following 0x00 frame is received correctly.
5. Send 0x55 with a single-tick glitch at tick 8 of data bit 3, and `i_en` every 3rd cycle -> `o_data`=0x55 (vote rejects the glitch). Latency scales by 3.
6. Pull `i_rst_n` low during data bit 4 -> all outputs 0, no `o_valid`. A back-to-back pair 0x12, 0x34 after release -> two `o_valid` pulses with the correct data.
